// File: rtl/wb_rf_arbiter.sv
// Arbitrates the single RF write port between the in-order writeback stage and a one-entry
// buffer for late (multi-cycle unit) results, with a starvation limit that stalls writeback.
module wb_rf_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ws_we,
  input  logic [4:0]  ws_dest,
  input  logic [31:0] ws_wdata,
  input  logic [31:0] ws_pc,
  output logic        ws_stall,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_dest,
  input  logic [31:0] lu_wdata,
  input  logic [31:0] lu_pc,
  input  logic        flush,
  output logic        pend_valid,
  output logic [4:0]  pend_dest,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_we,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);

  localparam logic [3:0] Limit = STARVE_LIMIT[3:0];

  logic        buf_valid_q, buf_valid_d;
  logic [4:0]  buf_dest_q, buf_dest_d;
  logic [31:0] buf_wdata_q, buf_wdata_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_waddr_q, rf_waddr_d;
  logic [31:0] rf_wdata_q, rf_wdata_d;
  logic [31:0] wb_pc_q, wb_pc_d;

  logic        force_drain;
  logic        ws_win;
  logic        drain;
  logic        supersede;
  logic        accept;

  // Stall depends on registered state only, never on ws_we.
  assign force_drain = buf_valid_q & (starve_cnt_q == Limit);
  assign ws_win      = ws_we & ~force_drain;
  assign drain       = ~ws_win & buf_valid_q;
  assign supersede   = ws_win & buf_valid_q & (ws_dest == buf_dest_q);
  assign accept      = lu_valid & ~buf_valid_q & ~flush;

  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = 5'd0;
    rf_wdata_d = 32'd0;
    wb_pc_d    = 32'd0;
    if (ws_win) begin
      rf_we_d    = (ws_dest != 5'd0);
      rf_waddr_d = ws_dest;
      rf_wdata_d = ws_wdata;
      wb_pc_d    = ws_pc;
    end else if (buf_valid_q) begin
      rf_we_d    = (buf_dest_q != 5'd0);
      rf_waddr_d = buf_dest_q;
      rf_wdata_d = buf_wdata_q;
      wb_pc_d    = buf_pc_q;
    end
  end

  always_comb begin
    buf_valid_d  = buf_valid_q;
    buf_dest_d   = buf_dest_q;
    buf_wdata_d  = buf_wdata_q;
    buf_pc_d     = buf_pc_q;
    starve_cnt_d = starve_cnt_q;
    if (flush || drain || supersede) begin
      buf_valid_d = 1'b0;
    end else if (accept) begin
      buf_valid_d = 1'b1;
      buf_dest_d  = lu_dest;
      buf_wdata_d = lu_wdata;
      buf_pc_d    = lu_pc;
    end
    if (!buf_valid_q || flush || drain || supersede) begin
      starve_cnt_d = 4'd0;
    end else if (ws_win && starve_cnt_q != Limit) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      buf_valid_q  <= 1'b0;
      buf_dest_q   <= 5'd0;
      buf_wdata_q  <= 32'd0;
      buf_pc_q     <= 32'd0;
      starve_cnt_q <= 4'd0;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= 5'd0;
      rf_wdata_q   <= 32'd0;
      wb_pc_q      <= 32'd0;
    end else begin
      buf_valid_q  <= buf_valid_d;
      buf_dest_q   <= buf_dest_d;
      buf_wdata_q  <= buf_wdata_d;
      buf_pc_q     <= buf_pc_d;
      starve_cnt_q <= starve_cnt_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      wb_pc_q      <= wb_pc_d;
    end
  end

  assign ws_stall          = force_drain;
  assign lu_ready          = ~buf_valid_q;
  assign pend_valid        = buf_valid_q;
  assign pend_dest         = buf_dest_q;
  assign rf_we             = rf_we_q;
  assign rf_waddr          = rf_waddr_q;
  assign rf_wdata          = rf_wdata_q;
  assign debug_wb_pc       = wb_pc_q;
  assign debug_wb_rf_we    = {4{rf_we_q}};
  assign debug_wb_rf_wnum  = rf_waddr_q;
  assign debug_wb_rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_wb_rf_arbiter.sv
// Self-checking bench for wb_rf_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level model of the pending late result.
module tb_wb_rf_arbiter;

  localparam int unsigned Limit = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ws_we;
  logic [4:0]  ws_dest;
  logic [31:0] ws_wdata;
  logic [31:0] ws_pc;
  logic        ws_stall;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_dest;
  logic [31:0] lu_wdata;
  logic [31:0] lu_pc;
  logic        flush;
  logic        pend_valid;
  logic [4:0]  pend_dest;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_rf_arbiter #(.STARVE_LIMIT(Limit)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .ws_we             (ws_we),
    .ws_dest           (ws_dest),
    .ws_wdata          (ws_wdata),
    .ws_pc             (ws_pc),
    .ws_stall          (ws_stall),
    .lu_valid          (lu_valid),
    .lu_ready          (lu_ready),
    .lu_dest           (lu_dest),
    .lu_wdata          (lu_wdata),
    .lu_pc             (lu_pc),
    .flush             (flush),
    .pend_valid        (pend_valid),
    .pend_dest         (pend_dest),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_we    (debug_wb_rf_we),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    resetn = 1'b1; ws_we = 1'b0; ws_dest = 5'd0; ws_wdata = 32'd0; ws_pc = 32'd0;
    lu_valid = 1'b0; lu_dest = 5'd0; lu_wdata = 32'd0; lu_pc = 32'd0; flush = 1'b0;
  endtask

  task automatic offer_late(input logic [4:0] d, input logic [31:0] v, input logic [31:0] pc);
    lu_valid = 1'b1; lu_dest = d; lu_wdata = v; lu_pc = pc;
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 1'b0; ws_we = 1'b1; ws_dest = 5'd3; lu_valid = 1'b1; lu_dest = 5'd2; flush = 1'b1;
    tick();
    tick();
    n_vec++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL reset_rf_we got %b want 0", rf_we); end
    n_vec++; if (rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
      n_err++; $display("FAIL reset_rf got %h/%h want 0/0", rf_waddr, rf_wdata); end
    n_vec++; if (debug_wb_pc !== 32'd0 || debug_wb_rf_we !== 4'd0 || debug_wb_rf_wnum !== 5'd0 ||
                 debug_wb_rf_wdata !== 32'd0) begin
      n_err++; $display("FAIL reset_debug got %h %h %h %h want all 0", debug_wb_pc,
                        debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata); end
    n_vec++; if (pend_valid !== 1'b0 || ws_stall !== 1'b0 || lu_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_status got pend=%b stall=%b ready=%b want 0 0 1",
                        pend_valid, ws_stall, lu_ready); end
    idle_inputs();
    tick();
    n_vec++; if (rf_we !== 1'b0 || lu_ready !== 1'b1 || ws_stall !== 1'b0) begin
      n_err++; $display("FAIL idle_after_reset got we=%b ready=%b stall=%b want 0 1 0",
                        rf_we, lu_ready, ws_stall); end
  endtask

  task automatic test_uncontested();
    idle_inputs();
    offer_late(5'd5, 32'h1234, 32'h100);
    tick();
    lu_valid = 1'b0;
    n_vec++; if (pend_valid !== 1'b1 || pend_dest !== 5'd5 || lu_ready !== 1'b0) begin
      n_err++; $display("FAIL uncont_pend got v=%b d=%0d rdy=%b want 1 5 0",
                        pend_valid, pend_dest, lu_ready); end
    n_vec++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL uncont_early got we=%b want 0", rf_we); end
    tick();
    n_vec++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234) begin
      n_err++; $display("FAIL uncont_write got %b/%0d/%h want 1/5/1234", rf_we, rf_waddr, rf_wdata); end
    n_vec++; if (debug_wb_pc !== 32'h100 || debug_wb_rf_we !== 4'hf || debug_wb_rf_wnum !== 5'd5 ||
                 debug_wb_rf_wdata !== 32'h1234) begin
      n_err++; $display("FAIL uncont_debug got %h %h %0d %h want 100 f 5 1234", debug_wb_pc,
                        debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata); end
    n_vec++; if (pend_valid !== 1'b0) begin n_err++; $display("FAIL uncont_pend_drop got %b want 0", pend_valid); end
    tick();
    n_vec++; if (rf_we !== 1'b0 || rf_waddr !== 5'd0) begin
      n_err++; $display("FAIL uncont_hold got %b/%0d want 0/0", rf_we, rf_waddr); end
  endtask

  task automatic test_starvation();
    idle_inputs();
    offer_late(5'd7, 32'h77, 32'h700);
    tick();
    lu_valid = 1'b0;
    ws_we = 1'b1; ws_dest = 5'd3;
    for (int i = 0; i < int'(Limit); i++) begin
      ws_wdata = 32'h300 + 32'(i);
      n_vec++; if (ws_stall !== 1'b0) begin n_err++; $display("FAIL starve_nostall_%0d got 1 want 0", i); end
      tick();
      n_vec++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h300 + 32'(i)) begin
        n_err++; $display("FAIL starve_ws_%0d got %b/%0d/%h want 1/3/%h", i, rf_we, rf_waddr,
                          rf_wdata, 32'h300 + 32'(i)); end
    end
    n_vec++; if (ws_stall !== 1'b1) begin n_err++; $display("FAIL starve_stall got 0 want 1"); end
    ws_wdata = 32'h3ff;
    tick();
    n_vec++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h77) begin
      n_err++; $display("FAIL starve_drain got %b/%0d/%h want 1/7/77", rf_we, rf_waddr, rf_wdata); end
    n_vec++; if (ws_stall !== 1'b0 || pend_valid !== 1'b0) begin
      n_err++; $display("FAIL starve_release got stall=%b pend=%b want 0 0", ws_stall, pend_valid); end
    tick();
    n_vec++; if (rf_waddr !== 5'd3 || rf_wdata !== 32'h3ff) begin
      n_err++; $display("FAIL starve_retry got %0d/%h want 3/3ff", rf_waddr, rf_wdata); end
    idle_inputs();
    tick();
  endtask

  task automatic test_supersede();
    idle_inputs();
    offer_late(5'd9, 32'hAAAA, 32'h900);
    tick();
    lu_valid = 1'b0;
    ws_we = 1'b1; ws_dest = 5'd9; ws_wdata = 32'hBBBB; ws_pc = 32'h904;
    n_vec++; if (pend_valid !== 1'b1 || pend_dest !== 5'd9) begin
      n_err++; $display("FAIL supersede_pend got %b/%0d want 1/9", pend_valid, pend_dest); end
    tick();
    ws_we = 1'b0;
    n_vec++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'hBBBB) begin
      n_err++; $display("FAIL supersede_write got %b/%0d/%h want 1/9/bbbb", rf_we, rf_waddr, rf_wdata); end
    n_vec++; if (pend_valid !== 1'b0) begin n_err++; $display("FAIL supersede_drop got 1 want 0"); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++; if (rf_we !== 1'b0) begin
        n_err++; $display("FAIL supersede_stale_%0d got we=%b addr=%0d want 0", i, rf_we, rf_waddr); end
    end
  endtask

  task automatic test_flush();
    idle_inputs();
    offer_late(5'd4, 32'h44, 32'h400);
    tick();
    offer_late(5'd6, 32'h66, 32'h600);
    flush = 1'b1;
    ws_we = 1'b1; ws_dest = 5'd2; ws_wdata = 32'h22; ws_pc = 32'h200;
    n_vec++; if (pend_valid !== 1'b1) begin n_err++; $display("FAIL flush_pend got 0 want 1"); end
    tick();
    idle_inputs();
    n_vec++; if (rf_we !== 1'b1 || rf_waddr !== 5'd2 || rf_wdata !== 32'h22) begin
      n_err++; $display("FAIL flush_ws_commit got %b/%0d/%h want 1/2/22", rf_we, rf_waddr, rf_wdata); end
    n_vec++; if (pend_valid !== 1'b0 || lu_ready !== 1'b1) begin
      n_err++; $display("FAIL flush_empty got pend=%b rdy=%b want 0 1", pend_valid, lu_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++; if (rf_we !== 1'b0 || pend_valid !== 1'b0) begin
        n_err++; $display("FAIL flush_no_write_%0d got we=%b addr=%0d pend=%b want 0", i, rf_we,
                          rf_waddr, pend_valid); end
    end
  endtask

  task automatic test_r0();
    idle_inputs();
    offer_late(5'd0, 32'h55, 32'h500);
    tick();
    lu_valid = 1'b0;
    n_vec++; if (pend_valid !== 1'b1) begin n_err++; $display("FAIL r0_pend got 0 want 1"); end
    tick();
    n_vec++; if (rf_we !== 1'b0 || debug_wb_rf_we !== 4'd0) begin
      n_err++; $display("FAIL r0_we got %b/%h want 0/0", rf_we, debug_wb_rf_we); end
    n_vec++; if (pend_valid !== 1'b0 || lu_ready !== 1'b1) begin
      n_err++; $display("FAIL r0_drain got pend=%b rdy=%b want 0 1", pend_valid, lu_ready); end
  endtask

  // Model: a pending late result plus how many arbitration rounds it has lost in a row.
  task automatic test_random();
    bit          m_valid = 1'b0;
    logic [4:0]  m_dest = '0;
    logic [31:0] m_data = '0;
    logic [31:0] m_pc = '0;
    int          m_lost = 0;
    bit          g;
    bit          was_valid;
    logic [4:0]  g_dest;
    logic [31:0] g_data;
    logic [31:0] g_pc;
    idle_inputs();
    resetn = 1'b0;
    tick();
    for (int c = 0; c < 3000; c++) begin
      resetn   = ($urandom_range(0, 99) != 0);
      ws_we    = $urandom_range(0, 1) == 1;
      ws_dest  = 5'($urandom_range(0, 7));
      ws_wdata = $urandom;
      ws_pc    = $urandom;
      lu_valid = $urandom_range(0, 2) != 0;
      lu_dest  = 5'($urandom_range(0, 7));
      lu_wdata = $urandom;
      lu_pc    = $urandom;
      flush    = ($urandom_range(0, 19) == 0);
      n_vec++; if (ws_stall !== (m_valid && m_lost == int'(Limit)) || lu_ready !== !m_valid ||
                   pend_valid !== m_valid || (m_valid && pend_dest !== m_dest)) begin
        n_err++; $display("FAIL rand_status_%0d got stall=%b rdy=%b pend=%b/%0d want %b %b %b/%0d",
                          c, ws_stall, lu_ready, pend_valid, pend_dest,
                          m_valid && m_lost == int'(Limit), !m_valid, m_valid, m_dest); end
      g = 1'b0; g_dest = '0; g_data = '0; g_pc = '0;
      was_valid = m_valid;
      if (!resetn) begin
        m_valid = 1'b0;
      end else begin
        if (ws_we && !(m_valid && m_lost == int'(Limit))) begin
          g = 1'b1; g_dest = ws_dest; g_data = ws_wdata; g_pc = ws_pc;
          if (m_valid && ws_dest == m_dest) m_valid = 1'b0;
          else if (m_valid) m_lost++;
        end else if (m_valid) begin
          g = 1'b1; g_dest = m_dest; g_data = m_data; g_pc = m_pc;
          m_valid = 1'b0;
        end
        if (flush) m_valid = 1'b0;
        else if (lu_valid && !was_valid) begin
          m_valid = 1'b1; m_dest = lu_dest; m_data = lu_wdata; m_pc = lu_pc;
        end
      end
      if (!m_valid) m_lost = 0;
      tick();
      n_vec++; if (rf_we !== (g && g_dest != 5'd0) || debug_wb_rf_we !== {4{g && g_dest != 5'd0}} ||
                   rf_waddr !== g_dest || debug_wb_rf_wnum !== g_dest) begin
        n_err++; $display("FAIL rand_we_%0d got %b/%h/%0d want %b/%0d", c, rf_we, debug_wb_rf_we,
                          rf_waddr, g && g_dest != 5'd0, g_dest); end
      if (!g || g_dest != 5'd0) begin
        n_vec++; if (rf_wdata !== g_data || debug_wb_rf_wdata !== g_data || debug_wb_pc !== g_pc) begin
          n_err++; $display("FAIL rand_data_%0d got %h/%h pc %h want %h pc %h", c, rf_wdata,
                            debug_wb_rf_wdata, debug_wb_pc, g_data, g_pc); end
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_uncontested();
    test_starvation();
    test_supersede();
    test_flush();
    test_r0();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
